// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe scheduler: FSM encoding, coordinate width
// and the default playfield parameters.
package pipe_pkg;

  localparam int X_W = 10;

  localparam int DEF_SLOTS    = 4;
  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_PIPE_W   = 60;
  localparam int DEF_SPEED    = 2;
  localparam int DEF_SPACING  = 200;
  localparam int DEF_GAP_BASE = 120;
  localparam int DEF_GAP_STEP = 16;
  localparam int DEF_BIRD_X   = 100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SPAWN = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: holds valid/x/gap, scrolls on move, loads on load, and flags
// retirement and bird-line crossings for the current move.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int SPEED    = DEF_SPEED,
  parameter int BIRD_X   = DEF_BIRD_X
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           move_i,
  input  logic           load_i,
  input  logic [X_W-1:0] load_gap_i,
  output logic           valid_o,
  output logic [X_W-1:0] x_o,
  output logic [X_W-1:0] gap_o,
  output logic           retire_o,
  output logic           cross_o
);

  localparam logic [X_W-1:0] SPD  = X_W'(SPEED);
  localparam logic [X_W-1:0] SCR  = X_W'(SCREEN_W);
  localparam logic [X_W:0]   PW   = (X_W+1)'(PIPE_W);
  localparam logic [X_W:0]   BX   = (X_W+1)'(BIRD_X);

  logic           valid_q, valid_d;
  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] gap_q, gap_d;
  logic [X_W-1:0] x_mv;
  logic [X_W:0]   old_r, new_r;

  // Position after this move; a retiring slot lands at 0.
  always_comb begin
    retire_o = valid_q && (x_q < SPD);
    x_mv     = retire_o ? '0 : (x_q - SPD);
    old_r    = {1'b0, x_q} + PW;
    new_r    = {1'b0, x_mv} + PW;
    cross_o  = valid_q && (old_r > BX) && (new_r <= BX);
  end

  always_comb begin
    valid_d = valid_q;
    x_d     = x_q;
    gap_d   = gap_q;
    if (load_i) begin
      valid_d = 1'b1;
      x_d     = SCR;
      gap_d   = load_gap_i;
    end else if (move_i && valid_q) begin
      if (retire_o) begin
        valid_d = 1'b0;
        x_d     = '0;
        gap_d   = '0;
      end else begin
        x_d = x_mv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      x_q     <= '0;
      gap_q   <= '0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      gap_q   <= gap_d;
    end
  end

  assign valid_o = valid_q;
  assign x_o     = x_q;
  assign gap_o   = gap_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe obstacle sequencer: per-frame scroll, retire, and spaced spawning.
// Optional scoring of pipes passing the bird is enabled by PIPE_SCORE_EN.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int SLOTS    = DEF_SLOTS,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int PIPE_W   = DEF_PIPE_W,
  parameter int SPEED    = DEF_SPEED,
  parameter int SPACING  = DEF_SPACING,
  parameter int GAP_BASE = DEF_GAP_BASE,
  parameter int GAP_STEP = DEF_GAP_STEP,
  parameter int BIRD_X   = DEF_BIRD_X
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic                 run,
  input  logic [3:0]           randbit,
  output logic [SLOTS-1:0]     pipe_valid,
  output logic [X_W*SLOTS-1:0] pipe_x,
  output logic [X_W*SLOTS-1:0] pipe_gap_y,
  output logic                 spawn,
`ifdef PIPE_SCORE_EN
  output logic [7:0]           score,
`endif
  output pipe_state_e          dbg_state,
  output logic [SLOTS-1:0]     dbg_retire,
  output logic [SLOTS-1:0]     dbg_cross
);

  localparam logic [X_W:0]   SPD_W = (X_W+1)'(SPEED);
  localparam logic [X_W:0]   SPC_W = (X_W+1)'(SPACING);
  localparam logic [X_W-1:0] SPC   = X_W'(SPACING);

  pipe_state_e    state_q, state_d;
  logic [X_W-1:0] dist_q, dist_d;
  logic           spawn_q, spawn_d;
  logic [X_W:0]   dist_sum;
  logic [X_W-1:0] gap_new;
  logic [SLOTS-1:0] free_oh, load_vec, retire_vec, cross_vec;
  logic           free_found;
  logic           move;

  assign move    = (state_q == ST_MOVE);
  assign gap_new = X_W'(GAP_BASE) + X_W'(randbit) * X_W'(GAP_STEP);

  // Lowest-index empty slot as a one-hot vector.
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (!free_found && !pipe_valid[i]) begin
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
    end
  end

  assign load_vec = (state_q == ST_SPAWN) ? free_oh : '0;

  always_comb begin
    state_d  = state_q;
    dist_d   = dist_q;
    spawn_d  = 1'b0;
    dist_sum = {1'b0, dist_q} + SPD_W;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick && run) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        dist_d  = (dist_sum >= SPC_W) ? SPC : dist_sum[X_W-1:0];
        state_d = (dist_sum >= SPC_W) ? ST_SPAWN : ST_IDLE;
      end
      ST_SPAWN: begin
        // With every slot busy, dist stays saturated and the spawn retries next frame.
        if (free_found) begin
          dist_d  = '0;
          spawn_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dist_q  <= SPC;
      spawn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dist_q  <= dist_d;
      spawn_q <= spawn_d;
    end
  end

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    pipe_slot #(
      .SCREEN_W(SCREEN_W),
      .PIPE_W  (PIPE_W),
      .SPEED   (SPEED),
      .BIRD_X  (BIRD_X)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .move_i    (move),
      .load_i    (load_vec[g]),
      .load_gap_i(gap_new),
      .valid_o   (pipe_valid[g]),
      .x_o       (pipe_x[g*X_W +: X_W]),
      .gap_o     (pipe_gap_y[g*X_W +: X_W]),
      .retire_o  (retire_vec[g]),
      .cross_o   (cross_vec[g])
    );
  end

`ifdef PIPE_SCORE_EN
  logic [7:0]  score_q, score_d;
  logic [15:0] score_sum;

  always_comb begin
    score_sum = {8'd0, score_q};
    for (int i = 0; i < SLOTS; i++) begin
      if (move && cross_vec[i]) score_sum = score_sum + 16'd1;
    end
    score_d = (score_sum > 16'd255) ? 8'd255 : score_sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) score_q <= 8'd0;
    else     score_q <= score_d;
  end

  assign score = score_q;
`endif

  assign spawn      = spawn_q;
  assign dbg_state  = state_q;
  assign dbg_retire = move ? retire_vec : '0;
  assign dbg_cross  = move ? cross_vec : '0;

endmodule
